// File: rtl/hqc_pkg.sv
// Shared HQC decode constants: scheduler state encoding and the per-security-level
// codeword length, intermediate RAM address width and watchdog limit.
package hqc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RM_RUN = 2'd1,
      RS_RUN = 2'd2,
      FIN    = 2'd3
   } hqc_state_e;

   localparam int WD_W     = 16;
   localparam int WR_CNT_W = 8;

   localparam int          HQC_N1_128      = 46;
   localparam int          HQC_N1_192      = 56;
   localparam int          HQC_N1_256      = 90;
   localparam int          HQC_MID_AW_128  = 6;
   localparam int          HQC_MID_AW_192  = 6;
   localparam int          HQC_MID_AW_256  = 7;
   localparam logic [15:0] HQC_TIMEOUT_128 = 16'd4095;
   localparam logic [15:0] HQC_TIMEOUT_192 = 16'd4095;
   localparam logic [15:0] HQC_TIMEOUT_256 = 16'd4095;

   function automatic int hqc_n1(input int sec);
      case (sec)
         192:     return HQC_N1_192;
         256:     return HQC_N1_256;
         default: return HQC_N1_128;
      endcase
   endfunction

   function automatic int hqc_mid_aw(input int sec);
      case (sec)
         192:     return HQC_MID_AW_192;
         256:     return HQC_MID_AW_256;
         default: return HQC_MID_AW_128;
      endcase
   endfunction

   function automatic logic [15:0] hqc_timeout(input int sec);
      case (sec)
         192:     return HQC_TIMEOUT_192;
         256:     return HQC_TIMEOUT_256;
         default: return HQC_TIMEOUT_128;
      endcase
   endfunction

endpackage

// File: rtl/hqc_phase_timer.sv
// Per-phase watchdog: restarts on clear, counts while enabled, flags when the
// count reaches the limit.
module hqc_phase_timer
   import hqc_pkg::*;
#(
   parameter int W = WD_W
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         clear_i,
   input  logic         enable_i,
   input  logic [W-1:0] limit_i,
   output logic         expired_o
);

   logic [W-1:0] cnt_q, cnt_d;

   // Saturate rather than wrap so a huge limit can never alias to an early expiry.
   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (enable_i && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign expired_o = enable_i && (cnt_q == limit_i);

endmodule

// File: rtl/hqc_decod_sched.sv
// HQC decode scheduler: runs the RM decoder then the RS decoder, hands the shared
// intermediate RAM port to whichever one is active, and guards each phase with a watchdog.
module hqc_decod_sched
   import hqc_pkg::*;
#(
   parameter int          PARAM_SECURITY = 128,
   parameter int          N1             = hqc_n1(PARAM_SECURITY),
   parameter int          MID_AW         = hqc_mid_aw(PARAM_SECURITY),
   parameter logic [15:0] TIMEOUT        = hqc_timeout(PARAM_SECURITY)
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              start_i,
   output logic              busy_o,
   output logic              done_o,
   output logic              error_o,
   output logic              rm_start_o,
   input  logic              rm_done_i,
   output logic              rs_start_o,
   input  logic              rs_done_i,
   input  logic              rm_wr_i,
   input  logic [MID_AW-1:0] rm_addr_i,
   input  logic [7:0]        rm_data_i,
   input  logic              rs_rd_i,
   input  logic [MID_AW-1:0] rs_addr_i,
   output logic              mid_wr_o,
   output logic              mid_rd_o,
   output logic [MID_AW-1:0] mid_addr_o,
   output logic [7:0]        mid_data_o
);

   hqc_state_e          state_q, state_d;
   logic                rm_start_q, rm_start_d;
   logic                rs_start_q, rs_start_d;
   logic                error_q, error_d;
   logic [WR_CNT_W-1:0] wr_cnt_q, wr_cnt_d;
   logic                rm_own, rs_own, strobe_viol;
   logic                wd_clear, wd_en, wd_expired;

   assign rm_own = (state_q == RM_RUN);
   assign rs_own = (state_q == RS_RUN);

   // Idle strobes are harmless; anywhere else a non-owner strobe means a decoder misbehaved.
   assign strobe_viol = (state_q != IDLE) &&
                        ((rm_wr_i && !rm_own) || (rs_rd_i && !rs_own));

   always_comb begin
      state_d    = state_q;
      rm_start_d = 1'b0;
      rs_start_d = 1'b0;
      error_d    = error_q | strobe_viol;
      wr_cnt_d   = wr_cnt_q;
      case (state_q)
         IDLE: begin
            if (start_i) begin
               state_d    = RM_RUN;
               rm_start_d = 1'b1;
               error_d    = 1'b0;
               wr_cnt_d   = '0;
            end
         end
         RM_RUN: begin
            if (rm_wr_i && (wr_cnt_q != '1))
               wr_cnt_d = wr_cnt_q + 1'b1;
            // A done pulse wins over a watchdog expiry in the same cycle.
            if (rm_done_i) begin
               state_d    = RS_RUN;
               rs_start_d = 1'b1;
               if (wr_cnt_d != WR_CNT_W'(N1))
                  error_d = 1'b1;
            end else if (wd_expired) begin
               state_d = FIN;
               error_d = 1'b1;
            end
         end
         RS_RUN: begin
            if (rs_done_i) begin
               state_d = FIN;
            end else if (wd_expired) begin
               state_d = FIN;
               error_d = 1'b1;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         rm_start_q <= 1'b0;
         rs_start_q <= 1'b0;
         error_q    <= 1'b0;
         wr_cnt_q   <= '0;
      end else begin
         state_q    <= state_d;
         rm_start_q <= rm_start_d;
         rs_start_q <= rs_start_d;
         error_q    <= error_d;
         wr_cnt_q   <= wr_cnt_d;
      end
   end

   assign wd_clear = (state_d != state_q) && ((state_d == RM_RUN) || (state_d == RS_RUN));
   assign wd_en    = rm_own | rs_own;

   hqc_phase_timer #(
      .W (WD_W)
   ) u_timer (
      .clk_i     (clk_i),
      .rst_i     (rst_i),
      .clear_i   (wd_clear),
      .enable_i  (wd_en),
      .limit_i   (TIMEOUT),
      .expired_o (wd_expired)
   );

   assign busy_o     = rm_own | rs_own;
   assign done_o     = (state_q == FIN);
   assign error_o    = error_q;
   assign rm_start_o = rm_start_q;
   assign rs_start_o = rs_start_q;

   // Zero-latency port mux; unowned cycles present an all-zero bus.
   assign mid_wr_o   = rm_own & rm_wr_i;
   assign mid_rd_o   = rs_own & rs_rd_i;
   assign mid_addr_o = rm_own ? rm_addr_i : (rs_own ? rs_addr_i : '0);
   assign mid_data_o = rm_own ? rm_data_i : 8'h00;

endmodule

// File: tb/tb_hqc_decod_sched.sv
// Scoreboard bench for hqc_decod_sched: two instances (default watchdog and a
// 100-cycle watchdog) share stimulus; a timeline model predicts every cycle.
module tb_hqc_decod_sched;

   localparam int N1     = 46;
   localparam int AW     = 6;
   localparam int TO_A   = 4095;
   localparam int TO_B   = 100;
   localparam int P_IDLE = 0;
   localparam int P_RM   = 1;
   localparam int P_RS   = 2;
   localparam int P_FIN  = 3;

   typedef struct {
      int            cyc;
      logic          busy, done, err, rm_st, rs_st, wr, rd, chk_addr, chk_data;
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_i, start_i, rm_done_i, rs_done_i, rm_wr_i, rs_rd_i;
   logic [AW-1:0] rm_addr_i, rs_addr_i;
   logic [7:0]    rm_data_i;
   logic [1:0]    busy_o, done_o, error_o, rm_start_o, rs_start_o, mid_wr_o, mid_rd_o;
   logic [AW-1:0] mid_addr_o [2];
   logic [7:0]    mid_data_o [2];

   int   checks = 0;
   int   failures = 0;
   exp_t qa [$];
   exp_t qb [$];
   logic err_m [2];

   always #5 clk = ~clk;

   hqc_decod_sched u_dut_a (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .busy_o(busy_o[0]), .done_o(done_o[0]), .error_o(error_o[0]),
      .rm_start_o(rm_start_o[0]), .rm_done_i(rm_done_i),
      .rs_start_o(rs_start_o[0]), .rs_done_i(rs_done_i),
      .rm_wr_i(rm_wr_i), .rm_addr_i(rm_addr_i), .rm_data_i(rm_data_i),
      .rs_rd_i(rs_rd_i), .rs_addr_i(rs_addr_i),
      .mid_wr_o(mid_wr_o[0]), .mid_rd_o(mid_rd_o[0]),
      .mid_addr_o(mid_addr_o[0]), .mid_data_o(mid_data_o[0])
   );

   hqc_decod_sched #(.TIMEOUT(16'd100)) u_dut_b (
      .clk_i(clk), .rst_i(rst_i), .start_i(start_i),
      .busy_o(busy_o[1]), .done_o(done_o[1]), .error_o(error_o[1]),
      .rm_start_o(rm_start_o[1]), .rm_done_i(rm_done_i),
      .rs_start_o(rs_start_o[1]), .rs_done_i(rs_done_i),
      .rm_wr_i(rm_wr_i), .rm_addr_i(rm_addr_i), .rm_data_i(rm_data_i),
      .rs_rd_i(rs_rd_i), .rs_addr_i(rs_addr_i),
      .mid_wr_o(mid_wr_o[1]), .mid_rd_o(mid_rd_o[1]),
      .mid_addr_o(mid_addr_o[1]), .mid_data_o(mid_data_o[1])
   );

   // Phase boundaries of one decode, in cycles after the start pulse (cycle 0).
   function automatic void plan(input int to, input int rm_at, input int rs_at,
                                output int re, output bit rt, output int se,
                                output bit st, output int fn);
      rt = (rm_at == 0) || (rm_at > to + 1);
      re = rt ? to + 1 : rm_at;
      se = 0;
      st = 1'b0;
      if (!rt) begin
         st = (rs_at <= re) || (rs_at > re + 1 + to);
         se = st ? re + 1 + to : rs_at;
      end
      fn = (rt ? re : se) + 1;
   endfunction

   function automatic int phase(input int c, input int re, input bit rt, input int se,
                                input int fn, input int rst_at);
      if (rst_at != 0 && c > rst_at) return P_IDLE;
      if (c == 0)                    return P_IDLE;
      if (c <= re)                   return P_RM;
      if (!rt && c <= se)            return P_RS;
      if (c == fn)                   return P_FIN;
      return P_IDLE;
   endfunction

   task automatic check_one(input string nm, input exp_t e, input int i);
      logic bad;
      bad = (busy_o[i] !== e.busy) || (done_o[i] !== e.done) || (error_o[i] !== e.err) ||
            (rm_start_o[i] !== e.rm_st) || (rs_start_o[i] !== e.rs_st) ||
            (mid_wr_o[i] !== e.wr) || (mid_rd_o[i] !== e.rd) ||
            (e.chk_addr && (mid_addr_o[i] !== e.addr)) ||
            (e.chk_data && (mid_data_o[i] !== e.data));
      checks++;
      if (bad) begin
         failures++;
         $display("FAIL %s cyc=%0d got busy=%b done=%b err=%b rms=%b rss=%b wr=%b rd=%b addr=%h data=%h | want busy=%b done=%b err=%b rms=%b rss=%b wr=%b rd=%b addr=%h(%b) data=%h(%b)",
                  nm, e.cyc, busy_o[i], done_o[i], error_o[i], rm_start_o[i], rs_start_o[i],
                  mid_wr_o[i], mid_rd_o[i], mid_addr_o[i], mid_data_o[i],
                  e.busy, e.done, e.err, e.rm_st, e.rs_st, e.wr, e.rd,
                  e.addr, e.chk_addr, e.data, e.chk_data);
      end
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (qa.size() > 0) begin e = qa.pop_front(); check_one("inst_to4095", e, 0); end
         if (qb.size() > 0) begin e = qb.pop_front(); check_one("inst_to100", e, 1); end
      end
   end

   // One decode: start at cycle 0, writes in cycles 2..n_wr+1, done pulses at rm_at/rs_at
   // (0 = never). viol 1: RS read during RM; viol 2: RM write during RS.
   task automatic run(input int n_wr, input int rm_at, input int rs_at, input int viol,
                      input bit stray, input int dup, input int rst_at);
      int   re [2], se [2], fn [2];
      bit   rt [2], st [2];
      int   cnt [2];
      int   last, p;
      bit   ev, post;
      exp_t e;
      for (int i = 0; i < 2; i++) begin
         plan((i == 0) ? TO_A : TO_B, rm_at, rs_at, re[i], rt[i], se[i], st[i], fn[i]);
         cnt[i] = 0;
      end
      last = (rst_at != 0) ? rst_at + 2 : ((fn[0] > fn[1]) ? fn[0] : fn[1]) + 2;
      for (int c = 0; c <= last; c++) begin
         @(posedge clk); #1;
         start_i   = (c == 0) || (dup != 0 && c == dup);
         rst_i     = (rst_at != 0 && c == rst_at);
         rm_wr_i   = (c >= 2 && c <= n_wr + 1) || (viol == 2 && c == rm_at + 2);
         rs_rd_i   = (c >= rm_at + 2 && c < rs_at && $urandom_range(0, 1) == 1) ||
                     (viol == 1 && c == 3);
         rm_done_i = (rm_at != 0 && c == rm_at) || (stray && c == rm_at + 2);
         rs_done_i = (rs_at != 0 && c == rs_at) || (stray && c == 5);
         rm_addr_i = AW'($urandom);
         rs_addr_i = AW'($urandom);
         rm_data_i = 8'($urandom);
         for (int i = 0; i < 2; i++) begin
            p          = phase(c, re[i], rt[i], se[i], fn[i], rst_at);
            post       = (rst_at != 0 && c == rst_at + 1);
            e.cyc      = c;
            e.busy     = (p == P_RM) || (p == P_RS);
            e.done     = (p == P_FIN);
            e.err      = err_m[i];
            e.rm_st    = (p == P_RM) && (c == 1);
            e.rs_st    = (p == P_RS) && (c == re[i] + 1);
            e.wr       = (p == P_RM) && rm_wr_i;
            e.rd       = (p == P_RS) && rs_rd_i;
            e.chk_addr = e.busy || post;
            e.addr     = post ? '0 : ((p == P_RM) ? rm_addr_i : rs_addr_i);
            e.chk_data = (p == P_RM) || post;
            e.data     = post ? 8'h00 : rm_data_i;
            if (i == 0) qa.push_back(e); else qb.push_back(e);
            ev = (rm_wr_i && p != P_RM && p != P_IDLE) || (rs_rd_i && p != P_RS && p != P_IDLE);
            if (p == P_RM && rm_wr_i) cnt[i]++;
            if (p == P_RM && c == re[i]) ev = ev || rt[i] || (cnt[i] != N1);
            if (p == P_RS && c == se[i]) ev = ev || st[i];
            if (c == 0 || (rst_at != 0 && c == rst_at)) err_m[i] = 1'b0;
            else                                         err_m[i] = err_m[i] | ev;
         end
      end
   endtask

   initial begin
      exp_t z;
      int   n_wr, rm_at, rs_at, viol;
      bit   stray;
      rst_i = 1'b1; start_i = 1'b0; rm_done_i = 1'b0; rs_done_i = 1'b0;
      rm_wr_i = 1'b0; rs_rd_i = 1'b0; rm_addr_i = '0; rs_addr_i = '0; rm_data_i = '0;
      err_m[0] = 1'b0; err_m[1] = 1'b0;
      z = '{cyc: -1, busy: 0, done: 0, err: 0, rm_st: 0, rs_st: 0, wr: 0, rd: 0,
            chk_addr: 1, chk_data: 1, addr: '0, data: 8'h00};
      @(posedge clk); #1;
      // Reset held with strobes toggling: every output must stay zero.
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         rm_wr_i = 1'b1; rs_rd_i = 1'b1; start_i = 1'b1;
         rm_addr_i = AW'($urandom); rs_addr_i = AW'($urandom); rm_data_i = 8'($urandom);
         qa.push_back(z); qb.push_back(z);
      end
      //   n_wr rm_at rs_at viol stray dup rst
      run(46,  200,  500,  0,   0,    0,  0);   // nominal; 100-cycle unit times out in RM
      run(45,   60,  120,  0,   0,    0,  0);   // short write count
      run(47,   60,  120,  0,   0,    0,  0);   // long write count
      run(46,    0,    0,  0,   0,    0,  0);   // no rm_done: both watchdogs fire
      run(46,   60,  120,  1,   0,    0,  0);   // RS read during RM
      run(46,   60,  120,  2,   0,    0,  0);   // RM write during RS
      run(46,   60,  140,  0,   0,   70, 90);   // start ignored in RS, then reset in RS
      run(46,   50,  151,  0,   0,    0,  0);   // rs_done meets watchdog limit
      run(46,  101,  160,  0,   0,    0,  0);   // rm_done meets watchdog limit
      run(46,   60,  130,  0,   1,    0,  0);   // out-of-phase done pulses ignored
      for (int r = 0; r < 12; r++) begin
         n_wr  = N1;
         if ($urandom_range(0, 3) == 0) n_wr = ($urandom_range(0, 1) == 1) ? N1 + 1 : N1 - 1;
         rm_at = n_wr + 3 + $urandom_range(0, 120);
         rs_at = rm_at + 4 + $urandom_range(0, 150);
         viol  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
         stray = ($urandom_range(0, 3) == 0);
         run(n_wr, rm_at, rs_at, viol, stray, 0, 0);
      end
      @(posedge clk); #1;
      start_i = 1'b0; rm_wr_i = 1'b0; rs_rd_i = 1'b0; rm_done_i = 1'b0; rs_done_i = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (qa.size() != 0 || qb.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain got pending=%0d/%0d want 0/0", qa.size(), qb.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL sim_time_limit got expired want finished");
      $fatal(1, "time limit");
   end

endmodule

// File: doc/hqc_decod_sched.md
HQC_DECOD_SCHED -- requirements
Module: hqc_decod_sched

Interface
REQ-001 SHALL have parameter PARAM_SECURITY, default 128; selects the HQC security level.
REQ-002 SHALL have parameter N1, default 46 (56 at 192, 90 at 256); the RS codeword length in bytes.
REQ-003 SHALL have parameter MID_AW, default 6 (6 at 192, 7 at 256); the intermediate RAM address width.
REQ-004 SHALL have parameter TIMEOUT, default 16'd4095; the per-phase watchdog limit in cycles.
REQ-005 SHALL have ports:
- clk_i  in  1  clock; one clock domain.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  start a decode; single-cycle pulse.
- busy_o  out  1  a decode is in progress.
- done_o  out  1  one-cycle completion pulse.
- error_o  out  1  sticky error status of the last decode.
- rm_start_o  out  1  start pulse to the RM decoder.
- rm_done_i  in  1  RM decoder done pulse.
- rs_start_o  out  1  start pulse to the RS decoder.
- rs_done_i  in  1  RS decoder done pulse.
- rm_wr_i  in  1  RM write strobe.
- rm_addr_i  in  MID_AW  RM write address.
- rm_data_i  in  8  RM write data.
- rs_rd_i  in  1  RS read strobe.
- rs_addr_i  in  MID_AW  RS read address.
- mid_wr_o  out  1  intermediate RAM write strobe.
- mid_rd_o  out  1  intermediate RAM read strobe.
- mid_addr_o  out  MID_AW  intermediate RAM address.
- mid_data_o  out  8  intermediate RAM write data.

Function
REQ-006 SHALL implement the FSM states IDLE, RM_RUN, RS_RUN and FIN.
REQ-007 SHALL, in IDLE, accept start_i: next state RM_RUN, rm_start_o high for exactly one cycle (the cycle after start_i), busy_o high from that cycle, error_o cleared.
REQ-008 SHALL ignore start_i outside IDLE, with no effect on state, counters or error_o.
REQ-009 SHALL, on rm_done_i in RM_RUN, go to RS_RUN and assert rs_start_o for one cycle on the following cycle.
REQ-010 SHALL, on rs_done_i in RS_RUN, go to FIN; in FIN done_o is high for one cycle, busy_o is low in that same cycle, and the next state is IDLE.
REQ-011 SHALL give ownership of the intermediate RAM port to RM in RM_RUN and to RS in RS_RUN; the mux is combinational with zero latency.
- mid_addr_o = rm_addr_i or rs_addr_i according to the owner.
- mid_data_o = rm_data_i.
REQ-012 SHALL drive mid_wr_o = rm_wr_i only in RM_RUN and mid_rd_o = rs_rd_i only in RS_RUN; otherwise both are 0.
REQ-013 SHALL drop any strobe from a non-owner (rm_wr_i outside RM_RUN, rs_rd_i outside RS_RUN) and set error_o, except in IDLE.
REQ-014 SHALL count accepted RM writes in an 8-bit counter cleared on start; rm_done_i with a count other than N1 SHALL set error_o, and the sequence still proceeds to RS_RUN.
REQ-015 SHALL run a 16-bit watchdog that clears on entry to RM_RUN and to RS_RUN and increments every cycle in those states.
REQ-016 SHALL, when the watchdog equals TIMEOUT, set error_o and go to FIN (done_o pulse), with no start pulse issued to the next phase.
REQ-017 SHALL give rm_done_i/rs_done_i priority over a timeout reached in the same cycle.
REQ-018 SHALL ignore rm_done_i outside RM_RUN and rs_done_i outside RS_RUN.
REQ-019 SHALL hold error_o until the next accepted start_i.

Reset
REQ-020 SHALL, on rst_i, force IDLE and zero busy_o, done_o, error_o, rm_start_o, rs_start_o, mid_wr_o, mid_rd_o, mid_addr_o, mid_data_o, the counters and the watchdog.
REQ-021 SHALL take reset mid-operation effect at the next clock edge, with no done_o pulse generated.

Structure
REQ-022 SHALL place the state encoding and the per-security N1/MID_AW/TIMEOUT constants in the shared package hqc_pkg.
REQ-023 SHALL implement the watchdog as sub-module hqc_phase_timer (clear, enable, limit in; expired out).

Verification
REQ-024 SHALL cover a nominal run: start, 46 RM writes, rm_done 200 cycles later, rs_done 300 cycles later -> rm_start at t+1, rs_start one cycle after rm_done, done_o one cycle, error_o=0.
REQ-025 SHALL cover a short RM write count: 45 RM writes then rm_done -> rs_start still issued, done_o at the end, error_o=1.
REQ-026 SHALL cover a timeout: TIMEOUT=100 and rm_done never asserted -> done_o in cycle 102 after start, no rs_start, error_o=1.
REQ-027 SHALL cover an ownership violation: rs_rd_i during RM_RUN -> mid_rd_o stays 0, error_o=1.
REQ-028 SHALL cover a restart: start_i during RS_RUN -> ignored; rst_i in RS_RUN -> IDLE next cycle, all outputs 0, no done_o.
REQ-029 SHALL cover a collision: rs_done_i in the same cycle the watchdog hits TIMEOUT -> normal completion, error_o=0.
